// File: rtl/pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_buffer
//  Description : Inter-stage pipeline register with a valid/ready handshake
//                and a one-entry skid register. up_ready is a function of
//                registered state and hold only, so back-pressure never
//                closes a combinational path from dn_ready to up_ready.
//                Hold freezes the stage, flush squashes it to a bubble, and
//                a saturating counter tracks how many beats flush discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buffer #(
    parameter int                 DATA_W      = 96,
    parameter int                 CTRL_W      = 12,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
    parameter logic [DATA_W-1:0]  BUBBLE_DATA = '0,
    parameter int                 CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    input  logic [CTRL_W-1:0] up_ctrl,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [CTRL_W-1:0] dn_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_count
);

    localparam logic [CNT_W-1:0] c_drop_max = {CNT_W{1'b1}};

    // Main register is always the head of the queue; skid holds the second beat.
    logic              r_main_v;
    logic              r_skid_v;
    logic [DATA_W-1:0] r_main_d;
    logic [DATA_W-1:0] r_skid_d;
    logic [CTRL_W-1:0] r_main_c;
    logic [CTRL_W-1:0] r_skid_c;
    logic [CNT_W-1:0]  r_drop_count;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_v_nxt;
    logic              w_skid_v_nxt;
    logic              w_load_main_up;
    logic              w_load_main_skid;
    logic              w_load_skid;
    logic [1:0]        w_drop_inc;
    logic [CNT_W+1:0]  w_drop_sum;
    logic [CNT_W-1:0]  w_drop_nxt;

    assign up_ready   = !r_skid_v && !hold;
    assign dn_valid   = r_main_v && !hold;
    assign dn_data    = dn_valid ? r_main_d : BUBBLE_DATA;
    assign dn_ctrl    = dn_valid ? r_main_c : BUBBLE_CTRL;
    assign occupancy  = {1'b0, r_main_v} + {1'b0, r_skid_v};
    assign drop_count = r_drop_count;

    assign w_in_fire  = up_valid && up_ready;
    assign w_out_fire = dn_valid && dn_ready;

    // A beat leaving downstream in the flush cycle was delivered, not dropped.
    // out_fire implies main_v, so the difference never goes negative.
    assign w_drop_inc = {1'b0, r_main_v} + {1'b0, r_skid_v} + {1'b0, w_in_fire}
                      - {1'b0, w_out_fire};
    assign w_drop_sum = {2'b00, r_drop_count} + {{CNT_W{1'b0}}, w_drop_inc};
    assign w_drop_nxt = (w_drop_sum > {2'b00, c_drop_max}) ? c_drop_max
                                                           : w_drop_sum[CNT_W-1:0];

    // Next-state selection: flush empties, hold freezes, otherwise FIFO moves.
    always_comb begin
        w_main_v_nxt     = r_main_v;
        w_skid_v_nxt     = r_skid_v;
        w_load_main_up   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_main_v_nxt = 1'b0;
            w_skid_v_nxt = 1'b0;
        end else if (!hold) begin
            if (w_out_fire) begin
                if (r_skid_v) begin
                    w_load_main_skid = 1'b1;
                    w_skid_v_nxt     = 1'b0;
                end else if (w_in_fire) begin
                    w_load_main_up   = 1'b1;
                end else begin
                    w_main_v_nxt     = 1'b0;
                end
            end else if (w_in_fire) begin
                if (!r_main_v) begin
                    w_load_main_up = 1'b1;
                    w_main_v_nxt   = 1'b1;
                end else begin
                    w_load_skid    = 1'b1;
                    w_skid_v_nxt   = 1'b1;
                end
            end
        end
    end

    // Valid bits and the drop counter carry the only reset-sensitive state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_v     <= 1'b0;
            r_skid_v     <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_main_v     <= w_main_v_nxt;
            r_skid_v     <= w_skid_v_nxt;
            if (flush) begin
                r_drop_count <= w_drop_nxt;
            end
        end
    end

    // Payload registers are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        if (w_load_main_up) begin
            r_main_d <= up_data;
            r_main_c <= up_ctrl;
        end else if (w_load_main_skid) begin
            r_main_d <= r_skid_d;
            r_main_c <= r_skid_c;
        end
        if (w_load_skid) begin
            r_skid_d <= up_data;
            r_skid_c <= up_ctrl;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_buffer
//  Description : Self-checking bench for pipe_stage_buffer against a
//                queue-based reference model of the stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buffer;

    localparam int               DW = 32;
    localparam int               CW = 12;
    localparam int               NW = 2;
    localparam logic [CW-1:0]    BC = 12'hA5C;
    localparam logic [DW-1:0]    BD = 32'hDEAD_BEEF;
    localparam int               VW = 1 + 1 + 2 + CW + DW + NW;

    logic          clk = 1'b0;
    logic          rst, hold, flush, up_valid, up_ready, dn_valid, dn_ready;
    logic [DW-1:0] up_data, dn_data;
    logic [CW-1:0] up_ctrl, dn_ctrl;
    logic [1:0]    occupancy;
    logic [NW-1:0] drop_count;

    int total = 0;
    int bad   = 0;

    // Reference model: ordered list of held beats plus a drop tally.
    logic [DW+CW-1:0] q[$];
    int               m_drop;

    pipe_stage_buffer #(
        .DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BC), .BUBBLE_DATA(BD), .CNT_W(NW)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_ctrl(up_ctrl),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data), .dn_ctrl(dn_ctrl),
        .occupancy(occupancy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic m_valid();
        return (q.size() > 0) && !hold;
    endfunction

    function automatic logic m_ready();
        return (q.size() < 2) && !hold;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [DW+CW-1:0] head;
        logic [DW-1:0]    d;
        logic [CW-1:0]    c;
        logic [1:0]       occ;
        logic [NW-1:0]    dr;
        d = BD;
        c = BC;
        if (m_valid()) begin
            head = q[0];
            d    = head[DW+CW-1:CW];
            c    = head[CW-1:0];
        end
        occ = 2'(q.size());
        dr  = NW'(m_drop);
        return {m_valid(), m_ready(), occ, c, d, dr};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {dn_valid, up_ready, occupancy, dn_ctrl, dn_data, drop_count};
    endfunction

    task automatic drive(input logic uv, input logic [DW-1:0] ud, input logic dr,
                         input logic h, input logic f);
        up_valid = uv;
        up_data  = ud;
        up_ctrl  = ud[CW-1:0] ^ 12'h3C3;
        dn_ready = dr;
        hold     = h;
        flush    = f;
        #1;
    endtask

    // Advance one clock and apply the stage rules to the model; ends at negedge.
    task automatic tick();
        logic             inf, outf;
        logic [DW+CW-1:0] beat;
        int               s;
        inf  = up_valid && m_ready();
        outf = m_valid() && dn_ready;
        beat = {up_data, up_ctrl};
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_drop = 0;
        end else if (flush) begin
            s = m_drop + q.size() + int'(inf) - int'(outf);
            m_drop = (s > 3) ? 3 : s;
            q.delete();
        end else if (!hold) begin
            if (outf) void'(q.pop_front());
            if (inf)  q.push_back(beat);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
        tick();
        total++;
        if ({dn_valid, dn_ctrl, dn_data, occupancy, drop_count, up_ready} !==
            {1'b0, BC, BD, 2'd0, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_outputs got %h exp %h",
                     {dn_valid, dn_ctrl, dn_data, occupancy, drop_count, up_ready},
                     {1'b0, BC, BD, 2'd0, 2'd0, 1'b1});
        end
        drive(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
        total++;
        if (up_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_ready got %b exp 0", up_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stream();
        logic [DW-1:0] got[$];
        for (int i = 0; i < 8; i++) begin
            drive(i < 5, DW'(i + 1), 1'b1, 1'b0, 1'b0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL stream c%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            if (dn_valid && dn_ready) got.push_back(dn_data);
            tick();
        end
        total++;
        if (got.size() != 5) begin
            bad++;
            $display("FAIL stream_count got %0d exp 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (got[i] !== DW'(i + 1)) begin
                    bad++;
                    $display("FAIL stream_order%0d got %h exp %h", i, got[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        drain();
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
            total++;
            if ({occupancy, up_ready, dn_valid, dn_data} !== {2'd2, 1'b0, 1'b1, 32'hA}) begin
                bad++;
                $display("FAIL bp_stall%0d got %h exp %h", i,
                         {occupancy, up_ready, dn_valid, dn_data}, {2'd2, 1'b0, 1'b1, 32'hA});
            end
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        total++;
        if (dn_data !== 32'hA) begin
            bad++;
            $display("FAIL bp_first got %h exp a", dn_data);
        end
        tick();
        total++;
        if ({dn_data, up_ready, occupancy} !== {32'hB, 1'b1, 2'd1}) begin
            bad++;
            $display("FAIL bp_second got %h exp %h", {dn_data, up_ready, occupancy},
                     {32'hB, 1'b1, 2'd1});
        end
        tick();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL bp_end got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_hold();
        drain();
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hE, 1'b1, 1'b1, 1'b0);
            total++;
            if ({dn_valid, dn_ctrl, dn_data, up_ready, occupancy} !== {1'b0, BC, BD, 1'b0, 2'd2}) begin
                bad++;
                $display("FAIL hold%0d got %h exp %h", i,
                         {dn_valid, dn_ctrl, dn_data, up_ready, occupancy}, {1'b0, BC, BD, 1'b0, 2'd2});
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            total++;
            if ({dn_valid, dn_data} !== ((i == 2) ? {1'b0, BD} : {1'b1, DW'(32'hA + i)})) begin
                bad++;
                $display("FAIL hold_release%0d got %h exp %h", i, {dn_valid, dn_data},
                         (i == 2) ? {1'b0, BD} : {1'b1, DW'(32'hA + i)});
            end
            tick();
        end
    endtask

    task automatic test_flush();
        drain();
        drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h12, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({dn_valid, dn_ctrl, occupancy, drop_count} !== {1'b0, BC, 2'd0, 2'd2}) begin
            bad++;
            $display("FAIL flush_two got %h exp %h", {dn_valid, dn_ctrl, occupancy, drop_count},
                     {1'b0, BC, 2'd0, 2'd2});
        end
        drive(1'b1, 32'h13, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h14, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({occupancy, drop_count} !== {2'd0, 2'd3}) begin
            bad++;
            $display("FAIL flush_sat got %h exp %h", {occupancy, drop_count}, {2'd0, 2'd3});
        end
        rst = 1'b1; tick(); rst = 1'b0;
        drive(1'b1, 32'h15, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1); tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({occupancy, drop_count} !== {2'd0, 2'd0}) begin
            bad++;
            $display("FAIL flush_delivered got %h exp %h", {occupancy, drop_count}, {2'd0, 2'd0});
        end
    endtask

    task automatic test_flush_hold();
        drive(1'b1, 32'h21, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h23, 1'b1, 1'b1, 1'b1); tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({occupancy, drop_count} !== {2'd0, 2'd2}) begin
            bad++;
            $display("FAIL flush_hold got %h exp %h", {occupancy, drop_count}, {2'd0, 2'd2});
        end
        drive(1'b1, 32'h24, 1'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h25, 1'b1, 1'b1, 1'b0); tick();
        end
        total++;
        if ({occupancy, drop_count, dn_valid} !== {2'd1, 2'd2, 1'b0}) begin
            bad++;
            $display("FAIL hold_only got %h exp %h", {occupancy, drop_count, dn_valid},
                     {2'd1, 2'd2, 1'b0});
        end
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(32'h40 + i), 1'b0, 1'b0, 1'b0); tick();
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({dn_valid, occupancy, drop_count, dn_ctrl} !== {1'b0, 2'd0, 2'd0, BC}) begin
            bad++;
            $display("FAIL async_reset got %h exp %h", {dn_valid, occupancy, drop_count, dn_ctrl},
                     {1'b0, 2'd0, 2'd0, BC});
        end
        @(negedge clk);
        q.delete();
        m_drop = 0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL async_after%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                  ($urandom % 8) == 0, ($urandom % 16) == 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random c%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        m_drop = 0;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_hold();
        test_flush();
        test_flush_hold();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) in every core of the multicore processor.
- Carries a data payload and a control bundle, and uses a valid/ready handshake with a one-entry skid register so back-pressure never creates a combinational ready path.
- Separate hold (freeze) and flush (squash to bubble) inputs from the hazard unit.
- Whenever the output is not valid, it presents a parameter-defined bubble (NOP) control word.

Parameters:
- DATA_W, 96: payload width (PC, operands, immediate, register addresses, etc.).
- CTRL_W, 12: control bundle width.
- BUBBLE_CTRL, 0: control value driven when dn_valid=0. ALU-op NOP encoding is folded in by the instantiating stage.
- BUBBLE_DATA, 0: payload value driven when dn_valid=0.
- CNT_W, 8: width of the saturating flush-drop counter.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-high reset.
- hold, in, 1: freeze buffer contents; no transfers in either direction.
- flush, in, 1: squash all held beats and any beat handshaken this cycle.
- up_valid, in, 1: upstream beat valid.
- up_ready, out, 1: buffer can accept a beat.
- up_data, in, DATA_W: upstream payload.
- up_ctrl, in, CTRL_W: upstream control bundle.
- dn_valid, out, 1: downstream beat valid.
- dn_ready, in, 1: downstream accepts the beat.
- dn_data, out, DATA_W: payload to the next stage.
- dn_ctrl, out, CTRL_W: control bundle to the next stage.
- occupancy, out, 2: entries held (0, 1 or 2).
- drop_count, out, CNT_W: saturating count of beats discarded by flush.

Behaviour:
- Storage: main register (main_v, main_d, main_c) and skid register (skid_v, skid_d, skid_c). States: EMPTY (main_v=0, skid_v=0), ONE (main_v=1, skid_v=0), TWO (both valid).
- Reset (asynchronous): main_v=0, skid_v=0, drop_count=0.
  - Outputs during and after reset: dn_valid=0, dn_ctrl=BUBBLE_CTRL, dn_data=BUBBLE_DATA, occupancy=0.
  - up_ready=1 unless hold=1.
  - Reset mid-transfer discards all beats and does not count them.
- Combinational outputs:
  - up_ready = !skid_v && !hold. Depends only on registers and hold, never on dn_ready.
  - dn_valid = main_v && !hold.
  - dn_ctrl = dn_valid ? main_c : BUBBLE_CTRL.
  - dn_data = dn_valid ? main_d : BUBBLE_DATA.
  - occupancy = main_v + skid_v.
- Handshakes: in_fire = up_valid && up_ready; out_fire = dn_valid && dn_ready.
- Priority is flush > hold > normal.
- Flush (evaluated at the clock edge):
  - Next state is EMPTY.
  - drop_count += main_v + skid_v + in_fire, saturating at 2^CNT_W-1.
  - out_fire in the same cycle still counts as delivered to the downstream stage and is not counted as dropped.
- Hold (flush=0): all registers retain their values, drop_count unchanged. Because up_ready and dn_valid are both 0, no fire occurs.
- Normal operation, next-state table (order strictly FIFO):
  - EMPTY, in_fire: load main. Next ONE. Latency 1 cycle: a beat accepted at edge N is on dn_* after edge N.
  - ONE, out_fire only: next EMPTY.
  - ONE, in_fire and out_fire together: main <= up beat; stays ONE.
  - ONE, in_fire only: skid <= up beat. Next TWO; up_ready drops the following cycle.
  - TWO, out_fire: main <= skid; skid_v=0. Next ONE. in_fire is impossible in TWO because up_ready=0.
  - Any state, no fire: registers unchanged.
- Throughput: 1 beat/cycle sustained while dn_ready=1.
- Data never changes on dn_* while dn_valid=1 and dn_ready=0 (stable-while-stalled rule).
- Payload registers need no reset. Only the valid bits and drop_count are reset.

Test Plan:
- Reset then stream: up_valid=1 with beats 0x1..0x5, dn_ready=1 constant. dn_valid rises 1 cycle after the first accept; dn_data=0x1..0x5 on consecutive cycles; occupancy stays 1; up_ready stays 1.
- Back-pressure: ONE holding 0xA, dn_ready=0, push 0xB. Next cycle occupancy=2, up_ready=0, dn_data=0xA stable. Raise dn_ready: outputs 0xA then 0xB; up_ready=1 the cycle after 0xA leaves.
- Hold: TWO state, hold=1 for 3 cycles with up_valid=1 and dn_ready=1. dn_valid=0, dn_ctrl=BUBBLE_CTRL, up_ready=0, contents preserved. After release: 0xA then 0xB, no loss or duplication.
- Flush: TWO state plus an in_fire-capable cycle (ONE with up_valid=1), flush=1. Next cycle EMPTY, dn_ctrl=BUBBLE_CTRL. drop_count +2 for TWO, +2 for ONE plus in_fire; CNT_W=2 saturates at 3.
- Flush and hold together: flush wins, buffer empties. Hold alone afterwards leaves drop_count unchanged.
- Async reset asserted mid-stream between clock edges: dn_valid falls immediately, occupancy=0, drop_count=0, no beats appear after release.
